// File: rtl/pll_mdrp_ctrl.sv
// PLL dynamic-reconfiguration port sequencer: pointer walk, 8-bit access,
// and reset/re-lock handling with timeout, all in the MD clock domain.
module pll_mdrp_ctrl #(
    parameter int ADDR_W       = 7,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int READ_LAT     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        md_opc,
    output logic              md_ainc,
    output logic [7:0]        md_wdi,
    input  logic [7:0]        md_rdo,
    output logic              pll_rst,
    input  logic              pll_lock_i,
    output logic              lock_o
);

    typedef enum logic [3:0] {
        S_BOOT_RST, S_BOOT_LOCK, S_IDLE, S_SEEK, S_WR,
        S_RD, S_RD_WAIT, S_RST, S_LOCK_WAIT, S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d, ptr_inc;
    logic [1:0]        op_q, op_d;
    logic [7:0]        wdata_q, wdata_d, rdata_q, rdata_d, wdi_q, wdi_d;
    logic              err_q, err_d, lock_o_q, lock_o_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d;
    logic              seek;

    assign ptr_inc = ptr_q + 1'b1;
    assign seek    = (cmd_addr != ptr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_BOOT_RST;
            cnt_q    <= '0;
            ptr_q    <= '0;
            addr_q   <= '0;
            op_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wdi_q    <= '0;
            err_q    <= 1'b0;
            lock_o_q <= 1'b0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            op_q     <= op_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            wdi_q    <= wdi_d;
            err_q    <= err_d;
            lock_o_q <= lock_o_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wdi_d   = wdi_q;
        err_d   = err_q;
        sync1_d = pll_lock_i;
        sync2_d = sync1_q;
        case (state_q)
            S_BOOT_RST:
                if (cnt_q == 32'(RST_CYCLES - 1)) state_d = S_BOOT_LOCK;
            S_BOOT_LOCK:
                if (sync2_q || cnt_q == 32'(LOCK_TIMEOUT - 1)) state_d = S_IDLE;
            S_IDLE:
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    err_d   = 1'b0;
                    rdata_d = 8'h00;
                    // zero seek distance goes straight to the access cycle
                    unique case (1'b1)
                        cmd_op == 2'b11:          begin state_d = S_RESP; err_d = 1'b1; end
                        cmd_op == 2'b10:          state_d = S_RST;
                        !cmd_op[1] && seek:       state_d = S_SEEK;
                        cmd_op == 2'b01 && !seek: state_d = S_WR;
                        cmd_op == 2'b00 && !seek: state_d = S_RD;
                    endcase
                end
            S_SEEK: begin
                ptr_d = ptr_inc;
                if (ptr_inc == addr_q) state_d = (op_q == 2'b00) ? S_RD : S_WR;
            end
            S_WR: begin
                wdi_d   = wdata_q;
                state_d = S_RESP;
            end
            S_RD:
                state_d = S_RD_WAIT;
            S_RD_WAIT:
                if (cnt_q == 32'(READ_LAT - 1)) begin
                    rdata_d = md_rdo;
                    state_d = S_RESP;
                end
            S_RST:
                if (cnt_q == 32'(RST_CYCLES - 1)) state_d = S_LOCK_WAIT;
            S_LOCK_WAIT:
                if (sync2_q) begin
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == 32'(LOCK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            S_RESP:
                state_d = S_IDLE;
            default:
                state_d = S_BOOT_RST;
        endcase
        if (state_d != state_q) cnt_d = '0;
        // based on next state so lock_o is low for every reset/relock cycle
        lock_o_d = sync2_q & ~(state_d inside {S_BOOT_RST, S_BOOT_LOCK, S_RST, S_LOCK_WAIT});
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        rsp_rdata = (state_q == S_RESP) ? rdata_q : 8'h00;
        rsp_err   = (state_q == S_RESP) & err_q;
        md_ainc   = (state_q == S_SEEK);
        pll_rst   = (state_q == S_BOOT_RST) || (state_q == S_RST);
        md_wdi    = (state_q == S_WR) ? wdata_q : wdi_q;
        lock_o    = lock_o_q;
        md_opc    = 2'b00;
        if (state_q == S_WR) md_opc = 2'b01;
        if (state_q == S_RD) md_opc = 2'b10;
    end

endmodule
